// File: rtl/qspi_pad_pkg.sv
// ---------------------------------------------------------------------------
// qspi_pad_pkg : shared reset values and request grouping for qspi_pad_if
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package qspi_pad_pkg;

  localparam int QSPI_MAX_LANES = 4;

  localparam logic PAD_CS_N_RST  = 1'b1;
  localparam logic PAD_CS_E_RST  = 1'b0;
  localparam logic PAD_SCK_RST   = 1'b0;
  localparam logic PAD_SCK_E_RST = 1'b0;

  typedef struct packed {
    logic                      cs_n;
    logic                      cs_e;
    logic                      sck;
    logic                      sck_e;
    logic [QSPI_MAX_LANES-1:0] sio_o;
    logic [QSPI_MAX_LANES-1:0] sio_e;
  } qspi_pad_req_t;

endpackage

`default_nettype wire

// File: rtl/qspi_sync2.sv
// ---------------------------------------------------------------------------
// qspi_sync2 : parametrised-width two-flop synchroniser, async reset to 0
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qspi_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

`default_nettype wire

// File: rtl/qspi_pad_if.sv
// ---------------------------------------------------------------------------
// qspi_pad_if : registered QSPI pad shim with turnaround guard and read strobe
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qspi_pad_if
  import qspi_pad_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int SAMPLE_DLY_MAX = 3,
  parameter int TURN_GAP       = 1
) (
  input  logic                                CLK,
  input  logic                                RES_N,
  input  logic                                CS_N_I,
  input  logic                                CS_E_I,
  input  logic                                SCK_I,
  input  logic                                SCK_E_I,
  input  logic [LANES-1:0]                    SIO_O_I,
  input  logic [LANES-1:0]                    SIO_E_I,
  input  logic [$clog2(SAMPLE_DLY_MAX+1)-1:0] SAMPLE_DLY,
  input  logic                                TURN_CLR,
  output logic [LANES-1:0]                    SIO_I_O,
  output logic                                SIO_VLD,
  output logic                                TURN_VIOL,
  output logic                                PAD_CS_N,
  output logic                                PAD_CS_E,
  output logic                                PAD_SCK,
  output logic                                PAD_SCK_E,
  output logic [LANES-1:0]                    PAD_SIO_O,
  output logic [LANES-1:0]                    PAD_SIO_E,
  input  logic [LANES-1:0]                    PAD_SIO_I
);

  localparam int DW = $clog2(SAMPLE_DLY_MAX+1);
  localparam int SW = SAMPLE_DLY_MAX + 1;
  localparam int CW = (TURN_GAP > 0) ? $clog2(TURN_GAP+1) : 1;

  qspi_pad_req_t req;

  logic             cs_n_q, cs_e_q, sck_q, sck_e_q, sck_prev_q;
  logic [LANES-1:0] sio_o_q;
  logic [LANES-1:0] sio_e_q, sio_e_d;
  logic [LANES-1:0] supp;
  logic [DW-1:0]    dly_q, dly_d, dly_clamp;
  logic             ev, ev_q;
  logic [SW-1:0]    evsr_q;
  logic             tap;
  logic [LANES-1:0] s2;
  logic [LANES-1:0] sio_i_q, sio_i_d;
  logic             vld_q;
  logic             viol_q, viol_d;

  always_comb begin
    req              = '0;
    req.cs_n         = CS_N_I;
    req.cs_e         = CS_E_I;
    req.sck          = SCK_I;
    req.sck_e        = SCK_E_I;
    req.sio_o[LANES-1:0] = SIO_O_I;
    req.sio_e[LANES-1:0] = SIO_E_I;
  end

  // Per-lane dead-time counter: loaded on the pad enable fall, blocks re-enable while nonzero.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [CW-1:0] gap_q, gap_d;

    always_comb begin
      gap_d = gap_q;
      if (gap_q != '0) gap_d = gap_q - 1'b1;
      if (sio_e_q[i] && !req.sio_e[i]) gap_d = CW'(TURN_GAP);
    end

    assign supp[i]    = req.sio_e[i] && (gap_q != '0);
    assign sio_e_d[i] = req.sio_e[i] && !supp[i];

    always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) gap_q <= '0;
      else        gap_q <= gap_d;
    end
  end

  always_comb begin
    dly_clamp = SAMPLE_DLY;
    if (int'(SAMPLE_DLY) > SAMPLE_DLY_MAX) dly_clamp = DW'(SAMPLE_DLY_MAX);
    dly_d = dly_q;
    if (cs_n_q && !req.cs_n) dly_d = dly_clamp;
  end

  assign ev      = sck_q && !sck_prev_q && sck_e_q && !cs_n_q;
  assign tap     = evsr_q[dly_q];
  assign sio_i_d = tap ? s2 : sio_i_q;
  assign viol_d  = (|supp) | (viol_q & ~TURN_CLR);

  qspi_sync2 #(
    .WIDTH(LANES)
  ) u_sync (
    .clk_i (CLK),
    .rst_ni(RES_N),
    .d_i   (PAD_SIO_I),
    .q_o   (s2)
  );

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      cs_n_q     <= PAD_CS_N_RST;
      cs_e_q     <= PAD_CS_E_RST;
      sck_q      <= PAD_SCK_RST;
      sck_e_q    <= PAD_SCK_E_RST;
      sck_prev_q <= PAD_SCK_RST;
      sio_o_q    <= '0;
      sio_e_q    <= '0;
      dly_q      <= '0;
      ev_q       <= 1'b0;
      evsr_q     <= '0;
      sio_i_q    <= '0;
      vld_q      <= 1'b0;
      viol_q     <= 1'b0;
    end else begin
      cs_n_q     <= req.cs_n;
      cs_e_q     <= req.cs_e;
      sck_q      <= req.sck;
      sck_e_q    <= req.sck_e;
      sck_prev_q <= sck_q;
      sio_o_q    <= req.sio_o[LANES-1:0];
      sio_e_q    <= sio_e_d;
      dly_q      <= dly_d;
      ev_q       <= ev;
      evsr_q     <= (evsr_q << 1) | SW'(ev_q);
      sio_i_q    <= sio_i_d;
      vld_q      <= tap;
      viol_q     <= viol_d;
    end
  end

  assign PAD_CS_N  = cs_n_q;
  assign PAD_CS_E  = cs_e_q;
  assign PAD_SCK   = sck_q;
  assign PAD_SCK_E = sck_e_q;
  assign PAD_SIO_O = sio_o_q;
  assign PAD_SIO_E = sio_e_q;
  assign SIO_I_O   = sio_i_q;
  assign SIO_VLD   = vld_q;
  assign TURN_VIOL = viol_q;

endmodule

`default_nettype wire

// File: tb/tb_qspi_pad_if.sv
// ---------------------------------------------------------------------------
// tb_qspi_pad_if : directed self-checking bench for qspi_pad_if
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_qspi_pad_if;

  logic       CLK = 1'b0;
  logic       RES_N;
  logic       CS_N_I, CS_E_I, SCK_I, SCK_E_I;
  logic [3:0] SIO_O_I, SIO_E_I;
  logic [1:0] SAMPLE_DLY;
  logic       TURN_CLR;
  logic [3:0] SIO_I_O;
  logic       SIO_VLD, TURN_VIOL;
  logic       PAD_CS_N, PAD_CS_E, PAD_SCK, PAD_SCK_E;
  logic [3:0] PAD_SIO_O, PAD_SIO_E, PAD_SIO_I;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  qspi_pad_if #(
    .LANES(4), .SAMPLE_DLY_MAX(3), .TURN_GAP(2)
  ) dut (
    .CLK(CLK), .RES_N(RES_N),
    .CS_N_I(CS_N_I), .CS_E_I(CS_E_I), .SCK_I(SCK_I), .SCK_E_I(SCK_E_I),
    .SIO_O_I(SIO_O_I), .SIO_E_I(SIO_E_I), .SAMPLE_DLY(SAMPLE_DLY),
    .TURN_CLR(TURN_CLR), .SIO_I_O(SIO_I_O), .SIO_VLD(SIO_VLD),
    .TURN_VIOL(TURN_VIOL), .PAD_CS_N(PAD_CS_N), .PAD_CS_E(PAD_CS_E),
    .PAD_SCK(PAD_SCK), .PAD_SCK_E(PAD_SCK_E), .PAD_SIO_O(PAD_SIO_O),
    .PAD_SIO_E(PAD_SIO_E), .PAD_SIO_I(PAD_SIO_I)
  );

  task automatic test_reset();
    RES_N = 1'b0;
    CS_N_I = 1'b1; CS_E_I = 1'b1; SCK_I = 1'b1; SCK_E_I = 1'b1;
    SIO_O_I = 4'hF; SIO_E_I = 4'hF; SAMPLE_DLY = 2'd3; TURN_CLR = 1'b1;
    PAD_SIO_I = 4'hF;
    repeat (4) @(posedge CLK);
    #1;
    checks++;
    if ({PAD_CS_N, PAD_CS_E, PAD_SCK, PAD_SCK_E} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl got %b want 1000", {PAD_CS_N, PAD_CS_E, PAD_SCK, PAD_SCK_E});
    end
    checks++;
    if ({PAD_SIO_O, PAD_SIO_E, SIO_I_O} !== 12'h000) begin
      errors++; $display("FAIL reset_sio got %h want 000", {PAD_SIO_O, PAD_SIO_E, SIO_I_O});
    end
    checks++;
    if ({SIO_VLD, TURN_VIOL} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got %b want 00", {SIO_VLD, TURN_VIOL});
    end
    @(negedge CLK);
    RES_N = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({PAD_CS_N, PAD_CS_E, PAD_SCK, PAD_SCK_E, PAD_SIO_O, PAD_SIO_E} !== 12'hFFF) begin
      errors++; $display("FAIL release_follow got %h want fff",
                         {PAD_CS_N, PAD_CS_E, PAD_SCK, PAD_SCK_E, PAD_SIO_O, PAD_SIO_E});
    end
    CS_N_I = 1'b1; CS_E_I = 1'b1; SCK_I = 1'b0; SCK_E_I = 1'b1;
    SIO_O_I = 4'h6; SIO_E_I = 4'h0; TURN_CLR = 1'b0; PAD_SIO_I = 4'h5;
    @(posedge CLK); #1;
    checks++;
    if ({PAD_CS_N, PAD_CS_E, PAD_SCK, PAD_SCK_E, PAD_SIO_O, PAD_SIO_E} !== 12'hD60) begin
      errors++; $display("FAIL idle_follow got %h want d60",
                         {PAD_CS_N, PAD_CS_E, PAD_SCK, PAD_SCK_E, PAD_SIO_O, PAD_SIO_E});
    end
    repeat (4) @(posedge CLK);
  endtask

  // PAD_SCK rises in cycle 3; data driven only in cycle 3+dly; strobe expected at 3+lat.
  task automatic test_read(input logic [1:0] dly_fall, input logic [1:0] dly_mid,
                           input int lat, input logic [3:0] data, input string name);
    int vcount = 0;
    SAMPLE_DLY = dly_fall;
    for (int c = 0; c < 16; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (SIO_VLD !== (c == 3 + lat)) begin
        errors++; $display("FAIL %s_vld cycle %0d got %b want %b", name, c, SIO_VLD, (c == 3 + lat));
      end
      if (c == 3 + lat) begin
        checks++;
        if (SIO_I_O !== data) begin
          errors++; $display("FAIL %s_data got %h want %h", name, SIO_I_O, data);
        end
      end
      if (SIO_VLD === 1'b1) vcount++;
      if (c == 0) CS_N_I = 1'b0;
      if (c == 1) SAMPLE_DLY = dly_mid;
      if (c == 2) SCK_I = 1'b1;
      if (c == 3) SCK_I = 1'b0;
      if (c == 8) CS_N_I = 1'b1;
      PAD_SIO_I = (c == lat) ? data : 4'h5;
    end
    checks++;
    if (vcount != 1) begin
      errors++; $display("FAIL %s_count got %0d want 1", name, vcount);
    end
  endtask

  task automatic test_back_to_back();
    int vcount = 0;
    logic [3:0] exp_d;
    SAMPLE_DLY = 2'd3;
    for (int c = 0; c < 30; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (SIO_VLD !== (c >= 9 && c <= 23 && (c % 2) == 1)) begin
        errors++; $display("FAIL b2b_vld cycle %0d got %b", c, SIO_VLD);
      end
      if (c >= 9 && c <= 23 && (c % 2) == 1) begin
        exp_d = 4'((c - 3) & 15);
        checks++;
        if (SIO_I_O !== exp_d) begin
          errors++; $display("FAIL b2b_data cycle %0d got %h want %h", c, SIO_I_O, exp_d);
        end
      end
      if (c == 23) begin
        checks++;
        if (PAD_CS_N !== 1'b1) begin
          errors++; $display("FAIL b2b_last_after_cs got cs_n %b want 1", PAD_CS_N);
        end
      end
      if (SIO_VLD === 1'b1) vcount++;
      if (c == 0)  CS_N_I = 1'b0;
      if (c == 17) CS_N_I = 1'b1;
      SCK_I = (c >= 2 && c <= 16 && (c % 2) == 0);
      PAD_SIO_I = 4'(c & 15);
    end
    checks++;
    if (vcount != 8) begin
      errors++; $display("FAIL b2b_count got %0d want 8", vcount);
    end
  endtask

  task automatic test_reset_mid();
    SAMPLE_DLY = 2'd0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      if (c == 0) CS_N_I = 1'b0;
      if (c == 2) SCK_I = 1'b1;
    end
    @(posedge CLK); #2;
    RES_N = 1'b0;
    #1;
    checks++;
    if ({PAD_CS_N, PAD_CS_E, PAD_SCK, PAD_SCK_E, SIO_VLD, TURN_VIOL} !== 6'b100000) begin
      errors++; $display("FAIL midrst_async got %b want 100000",
                         {PAD_CS_N, PAD_CS_E, PAD_SCK, PAD_SCK_E, SIO_VLD, TURN_VIOL});
    end
    checks++;
    if (SIO_I_O !== 4'h0) begin
      errors++; $display("FAIL midrst_data got %h want 0", SIO_I_O);
    end
    CS_N_I = 1'b1; SCK_I = 1'b0;
    @(negedge CLK);
    RES_N = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (SIO_VLD !== 1'b0) begin
        errors++; $display("FAIL midrst_no_strobe cycle %0d got %b want 0", c, SIO_VLD);
      end
    end
  endtask

  task automatic test_turnaround();
    for (int c = 0; c < 11; c++) begin
      @(posedge CLK); #1;
      if (c == 1 || c == 5) begin
        checks++;
        if (PAD_SIO_E[0] !== 1'b1) begin
          errors++; $display("FAIL turn_en cycle %0d got %b want 1", c, PAD_SIO_E[0]);
        end
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (PAD_SIO_E[0] !== 1'b0) begin
          errors++; $display("FAIL turn_gap cycle %0d got %b want 0", c, PAD_SIO_E[0]);
        end
      end
      if (c == 2 || c == 3 || c == 8 || c == 9) begin
        checks++;
        if (TURN_VIOL !== (c == 3 || c == 8)) begin
          errors++; $display("FAIL turn_viol cycle %0d got %b want %b", c, TURN_VIOL, (c == 3 || c == 8));
        end
      end
      case (c)
        0: SIO_E_I = 4'h1;
        1: SIO_E_I = 4'h0;
        2: SIO_E_I = 4'h1;
        6: SIO_E_I = 4'h0;
        7: begin SIO_E_I = 4'h1; TURN_CLR = 1'b1; end
        8: begin SIO_E_I = 4'h0; TURN_CLR = 1'b1; end
        9: TURN_CLR = 1'b0;
        default: ;
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_read(2'd2, 2'd2, 5, 4'hA, "dly2");
    test_read(2'd0, 2'd0, 3, 4'hC, "dly0");
    // 2'd3 is the clamped maximum; the mid-transaction change to 0 must be ignored.
    test_read(2'd3, 2'd0, 6, 4'h9, "latch3");
    test_read(2'd0, 2'd0, 3, 4'h6, "relatch0");
    test_back_to_back();
    test_reset_mid();
    test_turnaround();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
